// File: rtl/scoreboard_pkg.sv
// Shared constants, width helper and slot record for the multi-port command scoreboard.
package scoreboard_pkg;

  localparam int PROC_COUNT = 4;
  localparam int KEY_W_DEF  = 8;
  localparam int VAL_W_DEF  = 2;

  // Bits needed to hold the value n itself (0..n), e.g. a 0..ENTRIES occupancy counter.
  function automatic int clog2_1(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= n) w = i + 1;
    end
    return w;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [KEY_W_DEF-1:0] key;
    logic [VAL_W_DEF-1:0] val;
  } slot_t;

endpackage

// File: rtl/sb_match.sv
// Combinational key matcher: compares one key against every valid slot.
module sb_match #(
  parameter int ENTRIES = 8,
  parameter int KEY_W   = 8,
  parameter int IDX_W   = 3
) (
  input  logic [KEY_W-1:0]         i_key,
  input  logic [ENTRIES-1:0]       i_valid,
  input  logic [ENTRIES*KEY_W-1:0] i_keys,
  output logic [ENTRIES-1:0]       o_hit_vec,
  output logic                     o_any_hit,
  output logic [IDX_W-1:0]         o_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_cmp
      assign o_hit_vec[gi] = i_valid[gi] && (i_keys[gi*KEY_W +: KEY_W] == i_key);
    end
  endgenerate

  assign o_any_hit = |o_hit_vec;

  // Keys are unique among valid slots, so at most one bit is set and OR-encoding is exact.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (o_hit_vec[i]) o_idx = o_idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/scoreboard_mp.sv
// Multi-port associative scoreboard: command ID -> processor ID, with insert/update,
// delete, flush and RD_PORTS pipelined lookups.
module scoreboard_mp
  import scoreboard_pkg::*;
#(
  parameter int ENTRIES  = 8,
  parameter int KEY_W    = KEY_W_DEF,
  parameter int VAL_W    = VAL_W_DEF,
  parameter int RD_PORTS = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_wr_valid,
  input  logic [KEY_W-1:0]            i_wr_key,
  input  logic [VAL_W-1:0]            i_wr_val,
  input  logic                        i_del_valid,
  input  logic [KEY_W-1:0]            i_del_key,
  input  logic                        i_flush,
  input  logic [RD_PORTS-1:0]         i_rd_valid,
  input  logic [RD_PORTS*KEY_W-1:0]   i_rd_key,
  output logic [RD_PORTS-1:0]         o_rd_ack,
  output logic [RD_PORTS-1:0]         o_rd_hit,
  output logic [RD_PORTS*VAL_W-1:0]   o_rd_val,
  output logic                        o_wr_err,
  output logic [clog2_1(ENTRIES)-1:0] o_count,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int CNT_W = clog2_1(ENTRIES);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]       r_valid;
  logic [KEY_W-1:0]         r_key [ENTRIES];
  logic [VAL_W-1:0]         r_val [ENTRIES];
  logic [CNT_W-1:0]         r_count;
  logic                     r_full;
  logic                     r_empty;
  logic                     r_wr_err;
  logic [RD_PORTS-1:0]      r_rd_ack;
  logic [RD_PORTS-1:0]      r_rd_hit;
  logic [RD_PORTS*VAL_W-1:0] r_rd_val;

  logic [ENTRIES*KEY_W-1:0] w_keys;
  logic [ENTRIES-1:0]       w_wr_hitvec;
  logic [ENTRIES-1:0]       w_del_hitvec;
  logic                     w_wr_hit;
  logic                     w_del_hit;
  logic [IDX_W-1:0]         w_wr_idx;
  logic [IDX_W-1:0]         w_del_idx;
  logic [RD_PORTS-1:0][ENTRIES-1:0] w_rd_hitvec;
  logic [RD_PORTS-1:0]              w_rd_hit;
  logic [RD_PORTS-1:0][IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]         w_free_idx;
  logic                     w_has_free;
  logic                     w_wr_kill;
  logic                     w_do_upd;
  logic                     w_do_alloc;
  logic                     w_do_del;
  logic                     w_wr_err;
  logic [CNT_W-1:0]         w_count_next;
  logic                     w_unused_hitvecs;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_keys
      assign w_keys[gi*KEY_W +: KEY_W] = r_key[gi];
    end
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd_match
      sb_match #(.ENTRIES(ENTRIES), .KEY_W(KEY_W), .IDX_W(IDX_W)) u_rd_match (
        .i_key    (i_rd_key[gi*KEY_W +: KEY_W]),
        .i_valid  (r_valid),
        .i_keys   (w_keys),
        .o_hit_vec(w_rd_hitvec[gi]),
        .o_any_hit(w_rd_hit[gi]),
        .o_idx    (w_rd_idx[gi])
      );
    end
  endgenerate

  sb_match #(.ENTRIES(ENTRIES), .KEY_W(KEY_W), .IDX_W(IDX_W)) u_wr_match (
    .i_key    (i_wr_key),
    .i_valid  (r_valid),
    .i_keys   (w_keys),
    .o_hit_vec(w_wr_hitvec),
    .o_any_hit(w_wr_hit),
    .o_idx    (w_wr_idx)
  );

  sb_match #(.ENTRIES(ENTRIES), .KEY_W(KEY_W), .IDX_W(IDX_W)) u_del_match (
    .i_key    (i_del_key),
    .i_valid  (r_valid),
    .i_keys   (w_keys),
    .o_hit_vec(w_del_hitvec),
    .o_any_hit(w_del_hit),
    .o_idx    (w_del_idx)
  );

  // Slot selection uses the encoded indices; the one-hot vectors are not needed here.
  assign w_unused_hitvecs = ^{w_rd_hitvec, w_wr_hitvec, w_del_hitvec};

  always_comb begin
    w_free_idx = '0;
    w_has_free = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  // A same-key delete cancels the write; a slot freed this cycle is never reused this cycle.
  always_comb begin
    w_wr_kill    = i_flush || (i_del_valid && (i_del_key == i_wr_key));
    w_do_upd     = i_wr_valid && !w_wr_kill && w_wr_hit;
    w_do_alloc   = i_wr_valid && !w_wr_kill && !w_wr_hit && w_has_free;
    w_wr_err     = i_wr_valid && !w_wr_kill && !w_wr_hit && !w_has_free;
    w_do_del     = i_del_valid && !i_flush && w_del_hit;
    w_count_next = i_flush ? '0 : (r_count + CNT_W'(w_do_alloc) - CNT_W'(w_do_del));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_key[i] <= '0;
        r_val[i] <= '0;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      if (w_do_del) r_valid[w_del_idx] <= 1'b0;
      if (w_do_upd) r_val[w_wr_idx] <= i_wr_val;
      if (w_do_alloc) begin
        r_valid[w_free_idx] <= 1'b1;
        r_key[w_free_idx]   <= i_wr_key;
        r_val[w_free_idx]   <= i_wr_val;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_wr_err <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_full   <= (w_count_next == CNT_W'(ENTRIES));
      r_empty  <= (w_count_next == '0);
      r_wr_err <= w_wr_err;
    end
  end

  // Lookups observe the table as it stood before this edge's modifications.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rd_ack <= '0;
      r_rd_hit <= '0;
      r_rd_val <= '0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        r_rd_ack[p] <= i_rd_valid[p];
        r_rd_hit[p] <= i_rd_valid[p] && w_rd_hit[p];
        r_rd_val[p*VAL_W +: VAL_W] <= (i_rd_valid[p] && w_rd_hit[p]) ? r_val[w_rd_idx[p]] : '0;
      end
    end
  end

  assign o_rd_ack = r_rd_ack;
  assign o_rd_hit = r_rd_hit;
  assign o_rd_val = r_rd_val;
  assign o_wr_err = r_wr_err;
  assign o_count  = r_count;
  assign o_full   = r_full;
  assign o_empty  = r_empty;

endmodule

// File: tb/tb_scoreboard_mp.sv
// Randomized and directed bench for scoreboard_mp against an associative-array reference model.
module tb_scoreboard_mp;

  localparam int ENTRIES  = 8;
  localparam int KEY_W    = 8;
  localparam int VAL_W    = 2;
  localparam int RD_PORTS = 2;
  localparam int CNT_W    = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      wr_valid;
  logic [KEY_W-1:0]          wr_key;
  logic [VAL_W-1:0]          wr_val;
  logic                      del_valid;
  logic [KEY_W-1:0]          del_key;
  logic                      flush;
  logic [RD_PORTS-1:0]       rd_valid;
  logic [RD_PORTS*KEY_W-1:0] rd_key;
  logic [RD_PORTS-1:0]       rd_ack;
  logic [RD_PORTS-1:0]       rd_hit;
  logic [RD_PORTS*VAL_W-1:0] rd_val;
  logic                      wr_err;
  logic [CNT_W-1:0]          count;
  logic                      full;
  logic                      empty;

  int model [int];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scoreboard_mp #(.ENTRIES(ENTRIES), .KEY_W(KEY_W), .VAL_W(VAL_W), .RD_PORTS(RD_PORTS)) dut (
    .i_clk      (clk),
    .i_rstn     (rst_n),
    .i_wr_valid (wr_valid),
    .i_wr_key   (wr_key),
    .i_wr_val   (wr_val),
    .i_del_valid(del_valid),
    .i_del_key  (del_key),
    .i_flush    (flush),
    .i_rd_valid (rd_valid),
    .i_rd_key   (rd_key),
    .o_rd_ack   (rd_ack),
    .o_rd_hit   (rd_hit),
    .o_rd_val   (rd_val),
    .o_wr_err   (wr_err),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_key = '0; wr_val = '0;
    del_valid = 1'b0; del_key = '0; flush = 1'b0;
    rd_valid = '0; rd_key = '0;
  endtask

  // One clock transaction: drive, predict from the model, clock, compare.
  task automatic cyc(input bit wv, input int wk, input int wd, input bit dv, input int dk,
                     input bit fl, input logic [1:0] rv, input int k0, input int k1);
    logic [RD_PORTS-1:0]       e_ack;
    logic [RD_PORTS-1:0]       e_hit;
    logic [RD_PORTS*VAL_W-1:0] e_val;
    logic                      e_err;
    int                        e_cnt;
    int                        keys [RD_PORTS];
    wk = wk & 255; dk = dk & 255; wd = wd & 3;
    keys[0] = k0 & 255; keys[1] = k1 & 255;
    wr_valid = wv; wr_key = KEY_W'(wk); wr_val = VAL_W'(wd);
    del_valid = dv; del_key = KEY_W'(dk); flush = fl;
    rd_valid = rv; rd_key = {KEY_W'(keys[1]), KEY_W'(keys[0])};

    e_ack = rv; e_hit = '0; e_val = '0; e_err = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rv[p] && model.exists(keys[p])) begin
        e_hit[p] = 1'b1;
        e_val[p*VAL_W +: VAL_W] = VAL_W'(model[keys[p]]);
      end
    end
    if (fl) begin
      model.delete();
    end else begin
      if (wv && !(dv && dk == wk)) begin
        if (model.exists(wk) || model.num() < ENTRIES) model[wk] = wd;
        else e_err = 1'b1;
      end
      if (dv && model.exists(dk)) model.delete(dk);
    end
    e_cnt = model.num();

    @(posedge clk);
    #1;
    check_val("rd_ack", 32'(rd_ack), 32'(e_ack));
    check_val("rd_hit", 32'(rd_hit), 32'(e_hit));
    check_val("rd_val", 32'(rd_val), 32'(e_val));
    check_val("wr_err", 32'(wr_err), 32'(e_err));
    check_val("count",  32'(count),  32'(e_cnt));
    check_val("full",   32'(full),   32'(e_cnt == ENTRIES));
    check_val("empty",  32'(empty),  32'(e_cnt == 0));
    $display("txn t=%0t wr=%0b/%0d/%0d del=%0b/%0d fl=%0b rd=%b/%0d/%0d -> ack=%b hit=%b val=%h err=%0b cnt=%0d",
             $time, wv, wk, wd, dv, dk, fl, rv, keys[0], keys[1], rd_ack, rd_hit, rd_val, wr_err, count);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ack"},   32'(rd_ack), 32'd0);
    check_val({tag, "_hit"},   32'(rd_hit), 32'd0);
    check_val({tag, "_val"},   32'(rd_val), 32'd0);
    check_val({tag, "_err"},   32'(wr_err), 32'd0);
    check_val({tag, "_count"}, 32'(count),  32'd0);
    check_val({tag, "_full"},  32'(full),   32'd0);
    check_val({tag, "_empty"}, 32'(empty),  32'd1);
  endtask

  initial begin
    int v4 [4];
    v4 = '{1, 2, 3, 0};
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 rst_n = 1'b1;

    for (int k = 1; k <= 4; k++) cyc(1, k, v4[k-1], 0, 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b01, 3, 0);

    cyc(0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
    for (int k = 10; k <= 17; k++) cyc(1, k, k, 0, 0, 0, 2'b00, 0, 0);
    cyc(1, 99, 1, 0, 0, 0, 2'b00, 0, 0);
    cyc(1, 12, 2, 0, 0, 0, 2'b11, 12, 99);
    cyc(1, 98, 1, 1, 10, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 1, 11, 0, 2'b00, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 2'b11, 5, 6);
    cyc(1, 7, 3, 1, 13, 0, 2'b00, 0, 0);
    cyc(1, 7, 2, 1, 7, 0, 2'b01, 7, 0);
    cyc(0, 0, 0, 1, 42, 0, 2'b10, 0, 7);
    cyc(1, 1, 2, 1, 14, 0, 2'b00, 0, 0);
    cyc(1, 20, 1, 0, 0, 1, 2'b01, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b01, 20, 0);

    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(0, 9) < 3, $urandom_range(0, 15), $urandom_range(0, 39) == 0,
          2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15));
    end

    cyc(1, 3, 1, 0, 0, 0, 2'b11, 3, 4);
    rd_valid = 2'b11; rd_key = {8'd3, 8'd4};
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    idle();
    model.delete();
    @(posedge clk);
    #1;
    check_val("rst_hold_ack", 32'(rd_ack), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_rel_ack", 32'(rd_ack), 32'd0);
    check_val("rst_rel_count", 32'(count), 32'd0);

    cyc(1, 3, 2, 0, 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'b11, 3, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scoreboard_mp.md
Name: scoreboard_mp

Overview:
- Parametrised multi-port successor of the command scoreboard: an associative table mapping command IDs (keys) to processor IDs (values), with unique keys.
- Supports insert/update, per-key delete, global flush, and RD_PORTS independent pipelined lookups with per-port acknowledge.
- Tracks occupancy with full/empty flags.
- Sits between the command dispatcher (writes/deletes) and the processor-completion logic (lookups).

Parameters:
- ENTRIES, 8, number of table slots (≥2).
- KEY_W, 8, command-ID width.
- VAL_W, 2, processor-ID width (clog2 of PROC_COUNT).
- RD_PORTS, 2, number of independent lookup ports (≥1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_wr_valid  in  1  insert/update request.
- i_wr_key  in  KEY_W  key to write.
- i_wr_val  in  VAL_W  value to write.
- i_del_valid  in  1  delete-by-key request.
- i_del_key  in  KEY_W  key to delete.
- i_flush  in  1  invalidate all entries.
- i_rd_valid  in  RD_PORTS  per-port lookup request.
- i_rd_key  in  RD_PORTS*KEY_W  per-port lookup key, port p at bits [p*KEY_W +: KEY_W].
- o_rd_ack  out  RD_PORTS  per-port result strobe.
- o_rd_hit  out  RD_PORTS  key found.
- o_rd_val  out  RD_PORTS*VAL_W  value found; 0 on miss.
- o_wr_err  out  1  one-cycle pulse: write dropped because the table was full.
- o_count  out  clog2(ENTRIES+1)  number of valid entries.
- o_full  out  1  o_count == ENTRIES.
- o_empty  out  1  o_count == 0.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rstn is asynchronous, active-low.
- Reset values: all valid bits 0, o_count 0, o_empty 1, o_full 0, o_rd_ack/o_rd_hit/o_rd_val 0, o_wr_err 0.
- Reset mid-operation: drops in-flight lookups with no ack.
- Storage: per slot {valid, key, val}. Keys are unique among valid slots.
- Lookup:
  - i_rd_valid[p] sampled at edge N; o_rd_ack[p]/o_rd_hit[p]/o_rd_val[p] are registered and valid for exactly one cycle after edge N+1 (latency 1).
  - Ports are fully pipelined: one request per port per cycle, and each request produces exactly one ack.
  - A lookup sees the table state before that edge's write/delete/flush (no bypass).
- Write, key present: value updated in place; o_count unchanged. This succeeds even when full.
- Write, key absent, not full: allocate the lowest-index invalid slot; o_count+1.
- Write, key absent, full: write dropped; o_wr_err pulses for one cycle after the edge; table unchanged.
- Delete, key present: clear valid; o_count−1.
- Delete, key absent: no-op, no error.
- Write and delete same cycle, same key: delete wins; the write is discarded with no error, leaving the key absent.
- Write and delete same cycle, different keys: both apply. The slot freed by the delete is not usable that cycle, so a write of a new key while full still reports o_wr_err.
- o_count per cycle changes by −1, 0 or +1, consistent with the rules above.
- Flush: highest priority. Clears all valid bits; o_count←0. Suppresses that cycle's write and delete, with no o_wr_err. Same-cycle lookups return pre-flush contents.
- o_full and o_empty are registered with o_count, so all three update together.
- Invariant: o_count equals the popcount of the valid bits at all times.

Decomposition:
- Package scoreboard_pkg:
  - default constants PROC_COUNT, KEY_W_DEF, VAL_W_DEF;
  - function clog2_1(n) for the counter width;
  - typedef slot_t {valid, key, val} sized from the default constants, used by benches for hierarchical inspection.
- Sub-module sb_match (combinational): compares one key against all slots and outputs a one-hot hit vector, any_hit, and encoded index. Instantiate RD_PORTS+2 times: one per lookup port, one for write, one for delete.
- Free-slot lowest-index priority encoder stays inline.

Test Plan:
- Reset, then insert keys 1..4 with values 1,2,3,0 → o_count=4, o_empty=0. Lookup key 3 on port 0 → next cycle o_rd_ack[0]=1, hit=1, val=3.
- Fill to ENTRIES=8 (keys 10..17), then write key 99 → o_wr_err pulses once, o_count stays 8, o_full=1. Then write key 12 with value 2 → updated, o_wr_err=0.
- Same cycle: port 0 looks up key 5 (present, val 1) and port 1 looks up key 6 (absent); back-to-back for 4 cycles → 4 acks per port, port 0 hit=1/val=1, port 1 hit=0/val=0.
- Write and delete key 7 in the same cycle (key 7 present) → key 7 absent, o_count−1. Then delete absent key 42 → no change.
- Flush together with write of key 20 and a lookup of key 1 (present) → lookup hit=1. Next cycle o_count=0 and o_empty=1; lookup of key 20 misses.
- Deassert i_rstn asynchronously mid-stream with lookups pending → all outputs 0 immediately, no stray ack after release.
